// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the serial CPU host-side bus port.
//   tx_state_t   : TX serialiser states (TX_IDLE, TX_SEND)
//   WORD_W_DEF   : default parallel word width
//   BUS_W_DEF    : default external bus width
//   CH_PC/CH_MDR/CH_MAR : customary TX channel assignment
//   cnt_width()  : counter width for n states, never less than one bit
// ---------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    localparam int WORD_W_DEF = 16;
    localparam int BUS_W_DEF  = 8;

    localparam int CH_PC  = 0;
    localparam int CH_MDR = 1;
    localparam int CH_MAR = 2;

    // A counter over a single state still needs one physical bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant over NUM_CH requesters.
//   clk, rst      : clock, asynchronous active-low reset
//   req           : per-channel request vector
//   advance       : strobe, the transfer of done_idx has just completed
//   done_idx      : channel whose transfer completed
//   grant_idx     : first requester at or after the pointer (combinational)
//   grant_valid   : at least one channel is requesting
// ---------------------------------------------------------------------------
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_CH = 3,
    localparam int PTR_W = cnt_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    input  logic [PTR_W-1:0]  done_idx,
    output logic [PTR_W-1:0]  grant_idx,
    output logic              grant_valid
);

    logic [PTR_W-1:0] ptr;

    // Search outward from the pointer, wrapping modulo NUM_CH, and take
    // the first channel that is requesting.
    always_comb begin
        int idx;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    // The pointer moves to just past the channel that finished, so that
    // channel gets lowest priority in the next arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance) begin
            if (int'(done_idx) == NUM_CH - 1)
                ptr <= '0;
            else
                ptr <= done_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/cpu_bus_port.sv
// ---------------------------------------------------------------------------
// cpu_bus_port
// Host-side bus interface of the serial CPU core.
//   TX: arbitrates NUM_CH parallel words and serialises the granted word
//       onto out_bus in BUS_W-wide beats, paced by ard_receive_ready.
//   RX: assembles ard_data_ready beats from in_bus into words offered on
//       rx_word/rx_valid, consumed with rx_take; overflow sets error.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   tx_req, tx_data    : per-channel request and flattened words
//   tx_ack             : pulse on the channel whose last beat is accepted
//   bus_sel, out_bus   : one-hot active channel and current TX beat
//   ard_receive_ready  : host accepts the current beat
//   ard_data_ready, in_bus : inbound beat strobe and data
//   rx_word, rx_valid, rx_take : assembled word handshake
//   busy               : TX is in SEND
//   error              : sticky RX overflow
// ---------------------------------------------------------------------------
module cpu_bus_port
    import cpu_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int BUS_W     = BUS_W_DEF,
    parameter int NUM_CH    = 3,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        tx_req,
    input  logic [NUM_CH*WORD_W-1:0] tx_data,
    output logic [NUM_CH-1:0]        tx_ack,
    output logic [NUM_CH-1:0]        bus_sel,
    output logic [BUS_W-1:0]         out_bus,
    input  logic                     ard_receive_ready,
    input  logic                     ard_data_ready,
    input  logic [BUS_W-1:0]         in_bus,
    output logic [WORD_W-1:0]        rx_word,
    output logic                     rx_valid,
    input  logic                     rx_take,
    output logic                     busy,
    output logic                     error
);

    localparam int BEATS = WORD_W / BUS_W;
    localparam int CNT_W = cnt_width(BEATS);
    localparam int PTR_W = cnt_width(NUM_CH);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if ((WORD_W % BUS_W) != 0) begin : g_bad_width
            $error("cpu_bus_port: WORD_W must be a multiple of BUS_W");
        end
    endgenerate

    // -----------------------------------------------------------------
    // TX
    // -----------------------------------------------------------------
    tx_state_t         state;
    logic [WORD_W-1:0] tx_shift;
    logic [CNT_W-1:0]  beat_cnt;
    logic [PTR_W-1:0]  cur_ch;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_valid;
    logic              last_accept;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (tx_req),
        .advance     (last_accept),
        .done_idx    (cur_ch),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign last_accept = (state == TX_SEND) && ard_receive_ready
                         && (beat_cnt == LAST_BEAT);

    // The current beat always sits at the outgoing end of the shift
    // register, so out_bus is just a fixed slice gated by busy.
    always_comb begin
        out_bus = '0;
        if (busy) begin
            if (MSB_FIRST != 0)
                out_bus = tx_shift[WORD_W-1 -: BUS_W];
            else
                out_bus = tx_shift[BUS_W-1:0];
        end
    end

    // The ack is tied to the accepting cycle itself, which is why it is
    // combinational; reset clears state, so it drops with no clock edge.
    always_comb begin
        tx_ack = '0;
        if (last_accept)
            tx_ack = NUM_CH'(1) << cur_ch;
    end

    // TX FSM: IDLE latches the granted word, SEND walks through the beats
    // as the host accepts them and always returns through IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= TX_IDLE;
            tx_shift <= '0;
            beat_cnt <= '0;
            cur_ch   <= '0;
            bus_sel  <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (grant_valid) begin
                        tx_shift <= tx_data[int'(grant_idx)*WORD_W +: WORD_W];
                        beat_cnt <= '0;
                        cur_ch   <= grant_idx;
                        bus_sel  <= NUM_CH'(1) << grant_idx;
                        busy     <= 1'b1;
                        state    <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (ard_receive_ready) begin
                        if (MSB_FIRST != 0)
                            tx_shift <= tx_shift << BUS_W;
                        else
                            tx_shift <= tx_shift >> BUS_W;
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            bus_sel  <= '0;
                            busy     <= 1'b0;
                            state    <= TX_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= TX_IDLE;
                    bus_sel <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------
    // RX
    // -----------------------------------------------------------------
    logic [WORD_W-1:0] rx_shift;
    logic [WORD_W-1:0] rx_next;
    logic [CNT_W-1:0]  rx_cnt;
    logic              rx_complete;

    // Shift-based assembly keeps the single-beat case free of zero-width
    // slices: MSB-first enters at the bottom, LSB-first at the top.
    always_comb begin
        rx_next = '0;
        if (MSB_FIRST != 0)
            rx_next = (rx_shift << BUS_W) | WORD_W'(in_bus);
        else
            rx_next = (rx_shift >> BUS_W) | (WORD_W'(in_bus) << (WORD_W - BUS_W));
    end

    assign rx_complete = ard_data_ready && (rx_cnt == LAST_BEAT);

    // A completed word is taken if the output slot is free or is being
    // emptied this same cycle; otherwise it is dropped and error sticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_shift <= '0;
            rx_cnt   <= '0;
            rx_word  <= '0;
            rx_valid <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (ard_data_ready) begin
                rx_shift <= rx_next;
                if (rx_complete)
                    rx_cnt <= '0;
                else
                    rx_cnt <= rx_cnt + CNT_W'(1);
            end
            if (rx_complete) begin
                if (!rx_valid || rx_take) begin
                    rx_word  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    error <= 1'b1;
                end
            end else if (rx_take) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cpu_bus_port.md
Name: cpu_bus_port

Overview:
- Parametrised host-side bus interface for the serial CPU core.
- Replaces the fixed three-source 8-bit output mux (PC/MDR/MAR) and the ad-hoc inbound byte shifting.
- TX: arbitrates NUM_CH parallel word sources, serialises the granted word onto a BUS_W-wide bus in beats, paced by host ready.
- RX: assembles inbound beats into words with a valid/take handshake and overflow detection.

Parameters:
- WORD_W, 16: width of one parallel word (PC/MDR/MAR/instruction).
- BUS_W, 8: external bus width; WORD_W mod BUS_W must be 0 (elaboration error otherwise).
- NUM_CH, 3: number of TX sources. Channel 0 = PC, 1 = MDR, 2 = MAR by convention.
- MSB_FIRST, 1: 1 = most-significant beat first on TX and RX; 0 = least-significant first.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- tx_req, input, NUM_CH: per-channel request to send its word.
- tx_data, input, NUM_CH*WORD_W: flattened words; channel i occupies bits [i*WORD_W +: WORD_W].
- tx_ack, output, NUM_CH: one-cycle pulse on the channel whose last beat was accepted.
- bus_sel, output, NUM_CH: one-hot, the channel currently driving out_bus; all zero when idle.
- out_bus, output, BUS_W: current TX beat; 0 when bus_sel is 0.
- ard_receive_ready, input, 1: host accepts the current out_bus beat this cycle.
- ard_data_ready, input, 1: in_bus carries a valid beat this cycle.
- in_bus, input, BUS_W: inbound beat.
- rx_word, output, WORD_W: last fully assembled word.
- rx_valid, output, 1: rx_word is unconsumed.
- rx_take, input, 1: consumer takes rx_word.
- busy, output, 1: TX FSM is in SEND.
- error, output, 1: sticky RX overflow flag.

Behaviour:
- Definitions: BEATS = WORD_W/BUS_W. Beat counters are $clog2(BEATS) bits wide (minimum 1 bit).
- Reset (rst = 0, asynchronous):
  - All outputs 0: bus_sel, out_bus, tx_ack, busy, rx_word, rx_valid, error.
  - TX FSM goes to IDLE; round-robin pointer = 0; partial TX/RX beats are discarded.
  - Reset asserted mid-transfer aborts it; no tx_ack is issued.
- TX FSM, states IDLE and SEND.
- IDLE:
  - If tx_req is nonzero, grant g = the first requesting channel at or after the round-robin pointer, wrapping modulo NUM_CH.
  - Latch tx_data[g] into the shift register, clear beat_cnt, set bus_sel = onehot(g) and busy = 1, go to SEND.
  - The first beat appears on out_bus the cycle after tx_req is sampled (1-cycle latency).
- SEND:
  - out_bus = the current beat.
  - A beat advances only on a cycle with ard_receive_ready = 1: shift by BUS_W and increment beat_cnt.
  - ard_receive_ready = 0 holds the beat and state indefinitely.
  - When the final beat (beat_cnt = BEATS-1) is accepted:
    - tx_ack[g] pulses for that cycle;
    - the pointer becomes (g+1) mod NUM_CH;
    - next state is IDLE, so bus_sel and busy clear the following cycle.
  - IDLE always lasts at least one cycle between transfers.
- tx_req and tx_data changes during SEND are ignored; the latched word completes.
- Beat order:
  - MSB_FIRST = 1: beat k = word[WORD_W-1-k*BUS_W -: BUS_W].
  - MSB_FIRST = 0: beat k = word[k*BUS_W +: BUS_W].
- BEATS = 1 degenerates to single-beat transfers: one accepted beat gives the ack.
- RX:
  - Independent of TX; always enabled.
  - Each cycle with ard_data_ready = 1 shifts in_bus into the assembly register per MSB_FIRST and increments rx_cnt.
  - On the BEATS-th beat, rx_cnt wraps to 0 and the completed word is offered to rx_word.
  - Offered word with rx_valid = 0, or rx_take = 1 in the same cycle: rx_word is loaded and rx_valid = 1.
  - Offered word with rx_valid = 1 and rx_take = 0 (overflow): the new word is dropped, rx_word is kept, error is set.
  - rx_take with no completion clears rx_valid next cycle; rx_take while rx_valid = 0 has no effect.
  - error clears only on reset.

Decomposition:
- Shared package cpu_pkg:
  - TX state enum tx_state_t {TX_IDLE, TX_SEND};
  - default width constants WORD_W_DEF = 16, BUS_W_DEF = 8;
  - channel index constants CH_PC = 0, CH_MDR = 1, CH_MAR = 2.
- One natural sub-module: rr_arbiter (parametrised NUM_CH, combinational grant from req plus pointer, registered pointer update on an advance strobe).
- The RX deserialiser stays inline.

Test Plan:
- Reset, then tx_req = 3'b001 with PC = 16'hA55A, MSB_FIRST = 1, ard_receive_ready held 1:
  - out_bus 8'hA5 then 8'h5A; bus_sel = 3'b001 for 2 cycles; tx_ack = 3'b001 pulses on the second beat.
- Back-pressure: same transfer with ard_receive_ready low for 3 cycles after the first beat:
  - 8'hA5 holds for 4 cycles total; no tx_ack until 8'h5A is accepted.
- Round robin: tx_req = 3'b111 held continuously:
  - grants in order channel 0, 1, 2, 0, with exactly one IDLE cycle between transfers.
- RX: beats 8'h12, 8'h34 with ard_data_ready:
  - rx_word = 16'h1234 and rx_valid = 1 the cycle after the second beat.
  - With MSB_FIRST = 0, rx_word = 16'h3412.
- Overflow: complete 16'h1234, no rx_take, then send 16'hBEEF:
  - rx_word stays 16'h1234 and error = 1.
  - Repeat with rx_take asserted in the 16'hBEEF completion cycle: rx_word = 16'hBEEF, error stays 0.
- Async reset asserted mid-SEND (after the first beat):
  - all outputs 0 immediately with no clock edge, no tx_ack.
  - Next request restarts from beat 0 with the pointer at 0.
